// File: rtl/aes_round_engine.sv
// Iterative AES engine: one full encrypt/decrypt round per clock, round keys fetched by rk_idx.
// Result appears NR+1 cycles after accept; DONE holds out_data until out_ready, no input accepted meanwhile.
module aes_round_engine #(
   parameter int NR    = 10,
   parameter int IDX_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [127:0]     in_data,
   input  logic             mode,
   output logic [IDX_W-1:0] rk_idx,
   input  logic [127:0]     rk_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [127:0]     out_data,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

   localparam logic [IDX_W-1:0] LAST = IDX_W'(NR);

   generate
      if (!(NR == 10 || NR == 12 || NR == 14)) begin : gBadNr
         $error("aes_round_engine: NR must be 10, 12 or 14");
      end
      if ((2 ** IDX_W) <= NR) begin : gBadIdx
         $error("aes_round_engine: IDX_W too narrow for NR");
      end
   endgenerate

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] sh;
      acc = 8'h00;
      sh  = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ sh;
         sh = xtime(sh);
      end
      return acc;
   endfunction

   // Multiplicative inverse as a^254 (a^2 * a^4 * ... * a^128); maps 0 to 0.
   function automatic logic [7:0] gfInv(input logic [7:0] a);
      logic [7:0] acc;
      logic [7:0] sq;
      acc = 8'h01;
      sq  = a;
      for (int i = 1; i < 8; i++) begin
         sq  = gfMul(sq, sq);
         acc = gfMul(acc, sq);
      end
      return acc;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
      logic [15:0] d;
      d = {b, b} << n;
      return d[15:8];
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] b);
      logic [7:0] v;
      v = gfInv(b);
      return v ^ rotl(v, 1) ^ rotl(v, 2) ^ rotl(v, 3) ^ rotl(v, 4) ^ 8'h63;
   endfunction

   function automatic logic [7:0] invSbox(input logic [7:0] b);
      return gfInv(rotl(b, 1) ^ rotl(b, 3) ^ rotl(b, 6) ^ 8'h05);
   endfunction

   // Byte 0 is the most significant byte; byte 4c+r is row r of column c.
   function automatic logic [7:0] byteAt(input logic [127:0] s, input int idx);
      return s[127-8*idx -: 8];
   endfunction

   function automatic logic [127:0] subBytes(input logic [127:0] s, input logic inv);
      logic [127:0] r;
      for (int i = 0; i < 16; i++)
         r[127-8*i -: 8] = inv ? invSbox(byteAt(s, i)) : sbox(byteAt(s, i));
      return r;
   endfunction

   function automatic logic [127:0] shiftRows(input logic [127:0] s, input logic inv);
      logic [127:0] r;
      for (int c = 0; c < 4; c++)
         for (int row = 0; row < 4; row++)
            r[127-8*(4*c+row) -: 8] =
               byteAt(s, 4*((inv ? (c - row + 4) : (c + row)) % 4) + row);
      return r;
   endfunction

   function automatic logic [127:0] mixColumns(input logic [127:0] s, input logic inv);
      logic [127:0] r;
      logic [7:0]   a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         for (int i = 0; i < 4; i++) begin
            a0 = byteAt(s, 4*c + i);
            a1 = byteAt(s, 4*c + (i+1)%4);
            a2 = byteAt(s, 4*c + (i+2)%4);
            a3 = byteAt(s, 4*c + (i+3)%4);
            r[127-8*(4*c+i) -: 8] = inv ?
               (gfMul(a0, 8'h0e) ^ gfMul(a1, 8'h0b) ^ gfMul(a2, 8'h0d) ^ gfMul(a3, 8'h09)) :
               (xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3);
         end
      end
      return r;
   endfunction

   fsm_t             fsm, fsmNext;
   logic [127:0]     state, stateNext;
   logic [IDX_W-1:0] rnd, rndNext;
   logic             mode_q, modeNext;

   logic             lastRnd;
   logic [127:0]     encT, decT, roundOut;

   assign lastRnd = (rnd == LAST);

   // Final round skips the (Inv)MixColumns stage.
   assign encT     = shiftRows(subBytes(state, 1'b0), 1'b0);
   assign decT     = subBytes(shiftRows(state, 1'b1), 1'b1) ^ rk_data;
   assign roundOut = mode_q ? (lastRnd ? decT : mixColumns(decT, 1'b1))
                            : ((lastRnd ? encT : mixColumns(encT, 1'b0)) ^ rk_data);

   always_ff @(posedge clk) begin
      if (rst) begin
         fsm    <= IDLE;
         state  <= '0;
         rnd    <= '0;
         mode_q <= 1'b0;
      end else begin
         fsm    <= fsmNext;
         state  <= stateNext;
         rnd    <= rndNext;
         mode_q <= modeNext;
      end
   end

   always_comb begin
      fsmNext   = fsm;
      stateNext = state;
      rndNext   = rnd;
      modeNext  = mode_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      rk_idx    = '0;
      case (fsm)
         IDLE: begin
            in_ready = 1'b1;
            rk_idx   = mode ? LAST : '0;
            if (in_valid) begin
               stateNext = in_data ^ rk_data;
               modeNext  = mode;
               rndNext   = IDX_W'(1);
               fsmNext   = ROUND;
            end
         end
         ROUND: begin
            rk_idx    = mode_q ? (LAST - rnd) : rnd;
            stateNext = roundOut;
            if (lastRnd) fsmNext = DONE;
            else         rndNext = rnd + IDX_W'(1);
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) fsmNext = IDLE;
         end
         default: fsmNext = IDLE;
      endcase
   end

   assign busy     = (fsm != IDLE);
   assign out_data = state;

endmodule

// File: tb/tb_aes_round_engine.sv
// Randomised scoreboard bench for aes_round_engine with NR=10 and NR=14 instances sharing host inputs.
module tb_aes_round_engine;

   localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT3 = 128'h8ea2b7ca516745bfeafc49904b496089;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst, mode, outReady;
   logic [127:0] inData;
   logic         v10, r10, ov10, busy10, v14, r14, ov14, busy14;
   logic [3:0]   k10, k14;
   logic [127:0] kd10, kd14, od10, od14;
   logic [127:0] rks10 [0:15];
   logic [127:0] rks14 [0:15];
   logic [7:0]   sb [0:255];

   logic [127:0] exp10 [$];
   logic [127:0] exp14 [$];
   int total = 0;
   int bad   = 0;

   assign kd10 = rks10[k10];
   assign kd14 = rks14[k14];

   aes_round_engine #(.NR(10), .IDX_W(4)) dut10 (
      .clk(clk), .rst(rst), .in_valid(v10), .in_ready(r10), .in_data(inData), .mode(mode),
      .rk_idx(k10), .rk_data(kd10), .out_valid(ov10), .out_ready(outReady), .out_data(od10),
      .busy(busy10));

   aes_round_engine #(.NR(14), .IDX_W(4)) dut14 (
      .clk(clk), .rst(rst), .in_valid(v14), .in_ready(r14), .in_data(inData), .mode(mode),
      .rk_idx(k14), .rk_data(kd14), .out_valid(ov14), .out_ready(outReady), .out_data(od14),
      .busy(busy14));

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   function automatic logic [7:0] rol8(input logic [7:0] x, input int n);
      return (x << n) | (x >> (8 - n));
   endfunction

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] r;
      r = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) r = r ^ a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      end
      return r;
   endfunction

   // S-box generated by walking generator 3 and its inverse in lockstep.
   task automatic buildSbox();
      logic [7:0] p, q, x;
      p = 8'h01;
      q = 8'h01;
      do begin
         p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
         q = q ^ (q << 1);
         q = q ^ (q << 2);
         q = q ^ (q << 4);
         if (q[7]) q = q ^ 8'h09;
         x = q ^ rol8(q, 1) ^ rol8(q, 2) ^ rol8(q, 3) ^ rol8(q, 4);
         sb[p] = x ^ 8'h63;
      end while (p != 8'h01);
      sb[0] = 8'h63;
   endtask

   task automatic setKey(input int w, input logic [255:0] key);
      logic [31:0] wd [0:59];
      logic [31:0] t;
      logic [7:0]  rc;
      int          nk;
      nk = (w == 14) ? 8 : 4;
      rc = 8'h01;
      for (int i = 0; i < nk; i++) wd[i] = key[255-32*i -: 32];
      for (int i = nk; i < 4*(w+1); i++) begin
         t = wd[i-1];
         if (i % nk == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
            rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
         end else if (nk > 6 && i % nk == 4) begin
            t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
         end
         wd[i] = wd[i-nk] ^ t;
      end
      for (int r = 0; r < 16; r++) begin
         if (w == 14) rks14[r] = (r <= w) ? {wd[4*r], wd[4*r+1], wd[4*r+2], wd[4*r+3]} : '0;
         else         rks10[r] = (r <= w) ? {wd[4*r], wd[4*r+1], wd[4*r+2], wd[4*r+3]} : '0;
      end
   endtask

   function automatic logic [127:0] rkOf(input int w, input int r);
      return (w == 14) ? rks14[r] : rks10[r];
   endfunction

   function automatic logic [127:0] aesEnc(input logic [127:0] pt, input int w);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [127:0] blk;
      blk = pt ^ rkOf(w, 0);
      for (int rnd = 1; rnd <= w; rnd++) begin
         for (int i = 0; i < 16; i++) t[i] = sb[blk[127-8*i -: 8]];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) s[4*c+r] = t[4*((c+r)%4)+r];
         if (rnd < w) begin
            for (int c = 0; c < 4; c++)
               for (int r = 0; r < 4; r++)
                  t[4*c+r] = gm(s[4*c+r], 8'h02) ^ gm(s[4*c+(r+1)%4], 8'h03)
                           ^ s[4*c+(r+2)%4] ^ s[4*c+(r+3)%4];
            for (int i = 0; i < 16; i++) s[i] = t[i];
         end
         for (int i = 0; i < 16; i++) blk[127-8*i -: 8] = s[i];
         blk = blk ^ rkOf(w, rnd);
      end
      return blk;
   endfunction

   function automatic logic gRdy(input int w);  return (w == 14) ? r14 : r10;   endfunction
   function automatic logic gOv(input int w);   return (w == 14) ? ov14 : ov10; endfunction
   function automatic logic [3:0] gIdx(input int w); return (w == 14) ? k14 : k10; endfunction

   task automatic setValid(input int w, input logic v);
      if (w == 14) v14 = v; else v10 = v;
   endtask

   // Returns at posedge+1 of the accept edge.
   task automatic send(input int w, input logic [127:0] d, input logic md, input logic [127:0] expv);
      int n;
      n = 0;
      @(negedge clk);
      inData = d;
      mode   = md;
      setValid(w, 1'b1);
      #1;
      while (!gRdy(w) && n < 100) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (n >= 100) begin
         total++;
         bad++;
         $display("FAIL accept%0d: in_ready got 0 want 1 within 100 cycles", w);
         setValid(w, 1'b0);
      end else begin
         chk($sformatf("rk_idx%0d at accept", w), 128'(gIdx(w)), 128'(md ? w : 0));
         if (w == 14) exp14.push_back(expv); else exp10.push_back(expv);
         @(posedge clk);
         #1;
         setValid(w, 1'b0);
      end
   endtask

   // Counts cycles to out_valid, checks the round-key index walk, and scrambles host inputs meanwhile.
   task automatic latency(input int w, input logic md);
      int n;
      bit seen;
      n    = 0;
      seen = 0;
      while (n < 40) begin
         @(negedge clk);
         #1;
         if (gOv(w)) begin
            seen = 1;
            break;
         end
         if (n < w)
            chk($sformatf("rk_idx%0d round %0d", w, n + 1), 128'(gIdx(w)),
                128'(md ? (w - 1 - n) : (n + 1)));
         inData = {$urandom, $urandom, $urandom, $urandom};
         mode   = ~mode;
         n++;
      end
      total++;
      if (!seen || n != w) begin
         bad++;
         $display("FAIL latency%0d: got %0d cycles want %0d", w, n, w);
      end
   endtask

   initial forever begin
      @(negedge clk);
      #2;
      if (!rst && ov10 && outReady) begin
         if (exp10.size() == 0) begin
            total++;
            bad++;
            $display("FAIL out10 unexpected: got %h want no output", od10);
         end else chk("out10", od10, exp10.pop_front());
      end
   end

   initial forever begin
      @(negedge clk);
      #2;
      if (!rst && ov14 && outReady) begin
         if (exp14.size() == 0) begin
            total++;
            bad++;
            $display("FAIL out14 unexpected: got %h want no output", od14);
         end else chk("out14", od14, exp14.pop_front());
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation got no end want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] p, c, hold, blkB;
      logic         md;
      int           w;

      buildSbox();
      rst = 1'b1; v10 = 1'b0; v14 = 1'b0; inData = '0; mode = 1'b0; outReady = 1'b1;
      setKey(10, {128'h000102030405060708090a0b0c0d0e0f, 128'h0});
      setKey(14, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      @(negedge clk);
      chk("reset in_ready10", 128'(r10), 128'(1));
      chk("reset out_valid10", 128'(ov10), 128'(0));
      chk("reset busy10", 128'(busy10), 128'(0));
      chk("reset rk_idx10", 128'(k10), 128'(0));
      chk("reset out_data10", od10, 128'h0);
      chk("reset in_ready14", 128'(r14), 128'(1));
      chk("reset out_valid14", 128'(ov14), 128'(0));

      send(10, PT, 1'b0, CT1);  latency(10, 1'b0);
      send(10, CT1, 1'b1, PT);  latency(10, 1'b1);
      send(14, PT, 1'b0, CT3);  latency(14, 1'b0);
      send(14, CT3, 1'b1, PT);  latency(14, 1'b1);

      // Reset in the fifth round of an encrypt.
      send(10, PT, 1'b0, CT1);
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      void'(exp10.pop_back());
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("abort out_valid", 128'(ov10), 128'(0));
      chk("abort in_ready", 128'(r10), 128'(1));
      chk("abort out_data", od10, 128'h0);
      repeat (15) @(negedge clk);
      chk("abort stays idle", 128'(busy10), 128'(0));
      send(10, PT, 1'b0, CT1);  latency(10, 1'b0);

      // Backpressure with a second block waiting.
      @(posedge clk);
      #1 outReady = 1'b0;
      send(10, PT, 1'b0, CT1);  latency(10, 1'b0);
      hold = od10;
      blkB = {$urandom, $urandom, $urandom, $urandom};
      inData = blkB; mode = 1'b0; v10 = 1'b1;
      exp10.push_back(aesEnc(blkB, 10));
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         #1;
         chk("stall out_data", od10, hold);
         chk("stall out_valid", 128'(ov10), 128'(1));
         chk("stall in_ready", 128'(r10), 128'(0));
      end
      outReady = 1'b1;
      @(negedge clk);
      #1;
      chk("post-handshake in_ready", 128'(r10), 128'(1));
      chk("post-handshake out_valid", 128'(ov10), 128'(0));
      @(posedge clk);
      #1 v10 = 1'b0;
      chk("second block accepted", 128'(busy10), 128'(1));
      latency(10, 1'b0);

      // Random blocks, modes and keys.
      for (int i = 0; i < 10; i++) begin
         w  = (i % 2 == 1) ? 14 : 10;
         p  = {$urandom, $urandom, $urandom, $urandom};
         md = 1'($urandom_range(0, 1));
         if (i % 3 == 2)
            setKey(w, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
         c = aesEnc(p, w);
         if (md) send(w, c, 1'b1, p);
         else    send(w, p, 1'b0, c);
         latency(w, md);
      end

      repeat (3) @(negedge clk);
      chk("scoreboard drained", 128'(exp10.size() + exp14.size()), 128'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/aes_round_engine.md
Name: aes_round_engine

Overview:
- Iterative AES block-cipher engine that runs one full round per clock over a single 128-bit state register.
- Selectable per block: encrypt, or decrypt using the InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns round order.
- Round count is parametrised for AES-128/192/256.
- Round keys come from an external key-schedule store, addressed by rk_idx.
- Sits between the host datapath (valid/ready) and the key schedule. Replaces the per-round combinational chains in the processor top level.

Parameters:
- NR, 10, number of rounds; legal values 10, 12, 14. Any other value is a synthesis error.
- IDX_W, 4, width of the round-key index; must satisfy 2**IDX_W > NR.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  input block present
- in_ready  output  1  engine can accept a block
- in_data  input  128  plaintext (mode=0) or ciphertext (mode=1)
- mode  input  1  0 = encrypt, 1 = decrypt; sampled only on the accept edge
- rk_idx  output  IDX_W  round-key index requested this cycle
- rk_data  input  128  round key for rk_idx; combinational, same cycle
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts the result
- out_data  output  128  result block
- busy  output  1  high in ROUND and DONE

Behaviour:
- States: IDLE, ROUND, DONE. Registers: state[127:0], rnd[IDX_W-1:0], mode_q.
- Reset, taking priority over everything:
  - FSM to IDLE; state, rnd, mode_q, out_data cleared to 0.
  - in_ready=1, out_valid=0, busy=0, rk_idx=0 in the cycle after reset.
  - Reset mid-operation discards the block silently. No out_valid is produced for it.
- IDLE:
  - in_ready=1.
  - rk_idx = mode ? NR : 0, driven combinationally from the live mode input.
  - Accept edge is in_valid & in_ready. On it: state <= in_data ^ rk_data; mode_q <= mode; rnd <= 1; go to ROUND.
- ROUND:
  - in_ready=0.
  - rk_idx = mode_q ? NR-rnd : rnd.
  - Encrypt round: SubBytes, ShiftRows, MixColumns, AddRoundKey.
  - Decrypt round: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns.
  - When rnd==NR the MixColumns / InvMixColumns stage is bypassed (final round).
  - Each edge: state <= round result. If rnd==NR, go to DONE; otherwise rnd <= rnd+1.
- DONE:
  - out_valid=1 and out_data=state.
  - Both are held stable while out_ready=0, for any number of cycles.
  - On out_valid & out_ready, go to IDLE.
  - No same-cycle re-accept: in_ready stays 0 in DONE.
- Latency and throughput:
  - Accept edge T; out_valid is first high in the cycle following edge T+NR.
  - Minimum spacing between accepts is NR+2 cycles.
- rk_idx is always within 0..NR.
- S-box and GF(2^8) xtime/multiply logic are combinational inside the round datapath. There is exactly one register stage per round.
- in_data, mode and rk_data outside the cycles where they are consumed are don't-care. Changes to in_data or mode while busy have no effect.
- out_data is a registered output and does not glitch with rk_data.

Test Plan:
- FIPS-197 C.1, NR=10, mode=0:
  - Stimulus: in 00112233445566778899aabbccddeeff, key schedule from 000102030405060708090a0b0c0d0e0f.
  - Response: out 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid first high exactly 11 cycles after accept.
- Same key, mode=1:
  - Stimulus: in 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Response: out 00112233445566778899aabbccddeeff.
  - rk_idx sequence observed is 10,9,...,0.
- NR=14 instance, FIPS-197 C.3:
  - Stimulus: key 000102...1e1f, encrypt 00112233445566778899aabbccddeeff.
  - Response: 8ea2b7ca516745bfeafc49904b496089 after 15 cycles. Decrypt of that value returns the plaintext.
- Backpressure:
  - Stimulus: out_ready=0 for 20 cycles after out_valid; in_valid held high with a second block throughout.
  - Response: out_data stable, in_ready=0 throughout, and the second block is accepted only after the out handshake completes plus one cycle in IDLE.
- Reset at round 5 of an encrypt:
  - Response: next cycle out_valid=0, in_ready=1, out_data=0. A fresh C.1 vector then completes correctly with no residue from the aborted block.
- Mode change while busy:
  - Stimulus: toggle mode and in_data every cycle during ROUND.
  - Response: result equals the block and mode captured at accept.
